// File: rtl/sorted_id_serializer.sv
// sorted_id_serializer
// Captures one ascending-sorted vector of N rule IDs from the bitonic merge
// stage, drops the all-ones padding sentinel and streams the surviving IDs,
// smallest first, one per cycle over a valid/ready interface.
//
// Build option: define SERIALIZER_DEDUP_EN to also drop an ID equal to its
// lower neighbour, so each distinct ID is emitted once.
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous active-low reset
//   in_valid   sorted vector on `in` is valid
//   in_ready   block can accept a vector (IDLE only)
//   in         N packed IDs, element i at bits [i*W : i*W+W-1]
//   out_valid  out_data holds an emitted ID
//   out_ready  downstream accepts the beat
//   out_data   emitted rule ID
//   out_last   final ID of the current vector
//   out_empty  one-cycle pulse when a vector held no valid IDs
//   busy       high in every state except IDLE
module sorted_id_serializer #(
    parameter int unsigned N           = 16,
    parameter int unsigned INPUT_WIDTH = 6,
    parameter int unsigned log_N       = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [0:N*INPUT_WIDTH-1]   in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [INPUT_WIDTH-1:0]     out_data,
    output logic                       out_last,
    output logic                       out_empty,
    output logic                       busy
);

    localparam logic [INPUT_WIDTH-1:0] SENTINEL = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREP,
        ST_EMIT
    } state_e;

    state_e                   state_q, state_d;
    logic [INPUT_WIDTH-1:0]   buf_q [N];
    logic [INPUT_WIDTH-1:0]   buf_d [N];
    logic [N-1:0]             mask_q, mask_d;
    logic [N-1:0]             mask_prep;
    logic [log_N-1:0]         idx_q, idx_d;
    logic [log_N-1:0]         last_idx_q, last_idx_d;

    logic                     in_ready_q, in_ready_d;
    logic                     busy_q, busy_d;
    logic                     out_valid_q, out_valid_d;
    logic [INPUT_WIDTH-1:0]   out_data_q, out_data_d;
    logic                     out_last_q, out_last_d;
    logic                     out_empty_q, out_empty_d;

    // Index of the lowest set bit (0 when none set).
    function automatic logic [log_N-1:0] lowest_set(input logic [N-1:0] v);
        lowest_set = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = log_N'(i);
        end
    endfunction

    // Index of the highest set bit (0 when none set).
    function automatic logic [log_N-1:0] highest_set(input logic [N-1:0] v);
        highest_set = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (v[i]) highest_set = log_N'(i);
        end
    endfunction

    // Lowest set bit strictly above cur.
    function automatic logic [log_N-1:0] next_above(input logic [N-1:0] v,
                                                    input logic [log_N-1:0] cur);
        next_above = cur;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (v[i] && (i > int'(cur))) next_above = log_N'(i);
        end
    endfunction

    // Keep mask for the captured vector.
    always_comb begin
        mask_prep    = '0;
        mask_prep[0] = (buf_q[0] != SENTINEL);
        for (int i = 1; i < int'(N); i++) begin
`ifdef SERIALIZER_DEDUP_EN
            mask_prep[i] = (buf_q[i] != SENTINEL) && (buf_q[i] != buf_q[i-1]);
`else
            mask_prep[i] = (buf_q[i] != SENTINEL);
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        mask_d     = mask_q;
        idx_d      = idx_q;
        last_idx_d = last_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    for (int i = 0; i < int'(N); i++) begin
                        buf_d[i] = in[i*INPUT_WIDTH +: INPUT_WIDTH];
                    end
                    state_d = ST_PREP;
                end
            end
            ST_PREP: begin
                mask_d     = mask_prep;
                last_idx_d = highest_set(mask_prep);
                if (mask_prep == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    idx_d   = lowest_set(mask_prep);
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (out_valid_q && out_ready) begin
                    if (out_last_q) state_d = ST_IDLE;
                    else            idx_d   = next_above(mask_q, idx_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered outputs follow the next state so they line up with it.
    always_comb begin
        in_ready_d  = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        out_valid_d = (state_d == ST_EMIT);
        out_data_d  = '0;
        out_last_d  = 1'b0;
        out_empty_d = (state_q == ST_PREP) && (mask_prep == '0);
        if (state_d == ST_EMIT) begin
            out_data_d = buf_d[idx_d];
            out_last_d = (idx_d == last_idx_d);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            for (int i = 0; i < int'(N); i++) buf_q[i] <= '0;
            mask_q      <= '0;
            idx_q       <= '0;
            last_idx_q  <= '0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_empty_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            mask_q      <= mask_d;
            idx_q       <= idx_d;
            last_idx_q  <= last_idx_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_empty_q <= out_empty_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_empty = out_empty_q;

endmodule

// File: tb/tb_sorted_id_serializer.sv
// Directed bench for sorted_id_serializer with hand-computed expected beats.
module tb_sorted_id_serializer;

    localparam int unsigned NE = 16;
    localparam int unsigned W  = 6;
    localparam int unsigned LN = 4;
    localparam logic [W-1:0] S = 6'h3F;

    typedef logic [W-1:0] vec_t [NE];

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [0:NE*W-1]   in_vec = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [W-1:0]      out_data;
    logic              out_last;
    logic              out_empty;
    logic              busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sorted_id_serializer #(.N(NE), .INPUT_WIDTH(W), .log_N(LN)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_empty (out_empty),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [0:NE*W-1] pack(input vec_t v);
        logic [0:NE*W-1] p;
        p = '0;
        for (int i = 0; i < int'(NE); i++) p[i*W +: W] = v[i];
        return p;
    endfunction

    // Present v (called just after a negedge), return just after the accept edge.
    task automatic offer(input string tag, input vec_t v);
        int cnt;
        cnt      = 0;
        in_vec   = pack(v);
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        check({tag, "_accept"}, 32'(in_ready), 32'd1);
        @(negedge clk);
    endtask

    task automatic expect_beat(input string tag, input logic [W-1:0] d, input logic l);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"},  32'(out_data),  32'(d));
        check({tag, "_last"},  32'(out_last),  32'(l));
        check({tag, "_empty"}, 32'(out_empty), 32'd0);
    endtask

    // Full transaction with out_ready held high.
    task automatic run_vec(input string tag, input vec_t v, input vec_t e, input int n);
        @(negedge clk);
        offer(tag, v);
        in_valid = 1'b0;
        check({tag, "_prep_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_prep_busy"},  32'(busy),      32'd1);
        check({tag, "_prep_ready"}, 32'(in_ready),  32'd0);
        if (n == 0) begin
            @(negedge clk);
            check({tag, "_empty"},       32'(out_empty), 32'd1);
            check({tag, "_empty_ready"}, 32'(in_ready),  32'd1);
            check({tag, "_empty_valid"}, 32'(out_valid), 32'd0);
            check({tag, "_empty_busy"},  32'(busy),      32'd0);
            @(negedge clk);
            check({tag, "_empty_pulse"}, 32'(out_empty), 32'd0);
        end else begin
            for (int k = 0; k < n; k++) begin
                @(negedge clk);
                expect_beat($sformatf("%s_b%0d", tag, k), e[k], k == n - 1);
            end
            @(negedge clk);
            check({tag, "_done_valid"}, 32'(out_valid), 32'd0);
            check({tag, "_done_ready"}, 32'(in_ready),  32'd1);
            check({tag, "_done_busy"},  32'(busy),      32'd0);
        end
    endtask

    initial begin
        vec_t v;
        vec_t e;
        vec_t b;

        // Reset state
        #12;
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_last",  32'(out_last),  32'd0);
        check("rst_out_empty", 32'(out_empty), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // 0..15, no sentinel
        for (int i = 0; i < int'(NE); i++) begin
            v[i] = W'(i);
            e[i] = W'(i);
        end
        run_vec("full", v, e, 16);

        // Duplicates plus sentinel padding
        v = '{default: S};
        v[0] = 6'd1; v[1] = 6'd1; v[2] = 6'd2; v[3] = 6'd2; v[4] = 6'd2; v[5] = 6'd5;
        e = '{default: '0};
`ifdef SERIALIZER_DEDUP_EN
        e[0] = 6'd1; e[1] = 6'd2; e[2] = 6'd5;
        run_vec("dup", v, e, 3);
`else
        e[0] = 6'd1; e[1] = 6'd1; e[2] = 6'd2; e[3] = 6'd2; e[4] = 6'd2; e[5] = 6'd5;
        run_vec("dup", v, e, 6);
`endif

        // All sentinel
        v = '{default: S};
        e = '{default: '0};
        run_vec("allS", v, e, 0);

        // Backpressure on the beat carrying 7
        v = '{default: S};
        v[0] = 6'd3; v[1] = 6'd7; v[2] = 6'd9;
        @(negedge clk);
        offer("bp", v);
        in_valid = 1'b0;
        @(negedge clk);
        expect_beat("bp_b0", 6'd3, 1'b0);
        @(negedge clk);
        expect_beat("bp_b1", 6'd7, 1'b0);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            expect_beat($sformatf("bp_hold%0d", k), 6'd7, 1'b0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        expect_beat("bp_b2", 6'd9, 1'b1);
        @(negedge clk);
        check("bp_done_valid", 32'(out_valid), 32'd0);
        check("bp_done_ready", 32'(in_ready),  32'd1);

        // Asynchronous reset during the beat carrying 7
        @(negedge clk);
        offer("ar", v);
        in_valid = 1'b0;
        @(negedge clk);
        expect_beat("ar_b0", 6'd3, 1'b0);
        @(negedge clk);
        expect_beat("ar_b1", 6'd7, 1'b0);
        #2 reset = 1'b0;
        #1;
        check("ar_in_ready",  32'(in_ready),  32'd0);
        check("ar_out_valid", 32'(out_valid), 32'd0);
        check("ar_out_data",  32'(out_data),  32'd0);
        check("ar_out_last",  32'(out_last),  32'd0);
        check("ar_out_empty", 32'(out_empty), 32'd0);
        check("ar_busy",      32'(busy),      32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("ar_rel_in_ready", 32'(in_ready),  32'd1);
        check("ar_rel_valid",    32'(out_valid), 32'd0);
        v = '{default: S};
        v[0] = 6'd4;
        e = '{default: '0};
        e[0] = 6'd4;
        run_vec("single", v, e, 1);

        // in_valid held across two vectors
        v = '{default: S};
        v[0] = 6'd10; v[1] = 6'd20;
        b = '{default: S};
        b[0] = 6'd30; b[1] = 6'd40; b[2] = 6'd50;
        @(negedge clk);
        offer("b2b_a", v);
        in_vec = pack(b);
        check("b2b_a_prep_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        expect_beat("b2b_a0", 6'd10, 1'b0);
        check("b2b_a0_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        expect_beat("b2b_a1", 6'd20, 1'b1);
        check("b2b_a1_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("b2b_idle_ready", 32'(in_ready),  32'd1);
        check("b2b_idle_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b_b_prep_ready", 32'(in_ready),  32'd0);
        check("b2b_b_prep_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        expect_beat("b2b_b0", 6'd30, 1'b0);
        @(negedge clk);
        expect_beat("b2b_b1", 6'd40, 1'b0);
        @(negedge clk);
        expect_beat("b2b_b2", 6'd50, 1'b1);
        @(negedge clk);
        check("b2b_done_valid", 32'(out_valid), 32'd0);
        check("b2b_done_ready", 32'(in_ready),  32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sorted_id_serializer.md
Name: sorted_id_serializer

Overview:
- Downstream consumer of the bitonic merge stage in the packet-classification pipeline.
- Captures one ascending-sorted vector of N rule IDs and removes the padding sentinel (all-ones ID).
- Optionally removes duplicate IDs.
- Emits the surviving IDs one per cycle, smallest first, over a valid/ready stream to the priority/action lookup stage.

Parameters:
- N, 16: number of elements in the sorted vector; power of two, at least 2.
- INPUT_WIDTH, 6: width of one rule ID in bits.
- log_N, 4: element index width; must equal $clog2(N).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  sorted vector on `in` is valid.
- in_ready  output  1  block can accept a vector.
- in  input  N*INPUT_WIDTH  sorted vector, declared [0:N*INPUT_WIDTH-1].
  - Element i occupies bits [i*INPUT_WIDTH : i*INPUT_WIDTH+INPUT_WIDTH-1].
  - Element 0 is the smallest.
- out_valid  output  1  out_data holds an emitted ID.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  INPUT_WIDTH  emitted rule ID.
- out_last  output  1  marks the final ID of the current vector; qualified by out_valid.
- out_empty  output  1  one-cycle pulse when a vector contained no valid IDs.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Sentinel S = all-ones at INPUT_WIDTH bits (6'h3F by default). S is never emitted.
- Handshakes: an input transfer occurs on an edge where in_valid && in_ready. An output transfer occurs on an edge where out_valid && out_ready.
- Reset (reset=0, asynchronous): state=IDLE and every output driven 0: in_ready, out_valid, out_data, out_last, out_empty, busy. Captured buffer and mask are cleared.
- in_ready = (state==IDLE), forced 0 while reset is asserted.
- FSM has three states.
- IDLE:
  - in_ready=1.
  - On an input transfer: latch `in` into buf[0..N-1], go to PREP.
- PREP (exactly one cycle):
  - Compute mask[i] = (buf[i]!=S) && (i==0 || buf[i]!=buf[i-1]); the second term applies only with dedup, see Optional Feature.
  - Register mask; last_idx = highest set bit of mask.
  - If mask==0: go to IDLE and assert out_empty for exactly the next cycle.
  - Otherwise: idx = lowest set bit of mask, go to EMIT.
- EMIT:
  - out_valid=1, out_data=buf[idx], out_last=(idx==last_idx).
  - On an output transfer with out_last=0: idx = next set bit of mask above idx (priority encoder).
  - On an output transfer with out_last=1: go to IDLE.
- Latency: first out_valid is asserted 2 cycles after the input-transfer edge. Throughput is then 1 ID per cycle while out_ready=1.
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_last and idx hold stable. out_valid never deasserts without a transfer.
- Back-to-back vectors: in_ready rises the cycle after the last output transfer. There is no overlap of capture and emission.
- The input vector is not checked for sortedness. Unsorted input still emits in index order; dedup then only removes adjacent equal IDs.
- An asynchronous reset mid-EMIT aborts the vector immediately: no out_last, buffer discarded.
- in_valid asserted while busy is ignored, and the upstream must hold the vector.

Optional Feature:
- Macro: SERIALIZER_DEDUP_EN.
- Defined: mask includes the adjacent-duplicate term, so each distinct ID is emitted once.
- Undefined: mask[i] = (buf[i]!=S) only. Every non-sentinel element is emitted, including repeats. The duplicate comparators are not synthesized.

Test Plan:
- Vector 0,1,...,15 (no S), out_ready=1 -> 16 beats with out_data 0..15 on consecutive cycles. out_last only on 15. First beat 2 cycles after accept.
- Vector 1,1,2,2,2,5,S x10 with dedup on -> beats 1,2,5, out_last on 5. With the macro undefined -> beats 1,1,2,2,2,5, out_last on the second... rather on the final 5.
- Vector all 6'h3F -> no out_valid. out_empty high exactly one cycle, 2 cycles after accept. in_ready returns high the same cycle out_empty is high.
- Vector 3,7,9,S... with out_ready low for 3 cycles on the beat carrying 7 -> out_data=7 is held stable with out_valid=1. Sequence resumes 7,9 with out_last on 9.
- reset pulled low during the EMIT beat of 7 -> all outputs 0 immediately. After release: in_ready=1, and a new vector 4,S... emits a single beat 4 with out_last=1.
- in_valid held high with two vectors presented sequentially -> the second is accepted only on the cycle after the first vector's out_last transfer. No beats are lost or reordered.
